// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg -- shared constants and state encoding for the request arbiter.
//   NUM_REQ : number of requesters (a..d)
//   ID_W    : width of a binary requester index
//   HOLD_W  : width of the grant hold counter
//   state_t : arbiter FSM encoding (IDLE / GRANT)
// ---------------------------------------------------------------------------
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int HOLD_W  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage : arb_pkg

// File: rtl/req_arbiter_if.sv
// ---------------------------------------------------------------------------
// req_arbiter_if -- request/grant bundle between requesters and the arbiter.
//   req     : request vector, req[3]=a ... req[0]=d
//   gnt     : one-hot grant, same bit order as req
//   gnt_id  : binary index of the granted requester, 0 when nothing granted
//   gnt_vld : high while any grant is active
// Modports:
//   master : requester side (drives req)
//   slave  : arbiter side (drives the grant signals)
// ---------------------------------------------------------------------------
interface req_arbiter_if;
  import arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_vld;

  modport master (output req, input gnt, gnt_id, gnt_vld);
  modport slave  (input req, output gnt, gnt_id, gnt_vld);

endinterface : req_arbiter_if

// File: rtl/prio_pick4.sv
// ---------------------------------------------------------------------------
// prio_pick4 -- combinational 4-way winner selection.
// Scans the request bits starting at index 'start' and descending with
// wrap-around (start, start-1, ..., start-3 mod 4); the first set bit wins.
// With start=3 this is plain fixed priority req[3] > req[2] > req[1] > req[0].
//   req      : request bits
//   start    : first index examined
//   pick     : one-hot winner (0 when no request)
//   pick_id  : binary index of the winner (0 when no request)
//   pick_vld : any request present
// ---------------------------------------------------------------------------
module prio_pick4
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    start,
  output logic [NUM_REQ-1:0] pick,
  output logic [ID_W-1:0]    pick_id,
  output logic               pick_vld
);

  logic [ID_W-1:0] idx;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block leaves a variable unassigned and infers a latch.
  always_comb begin
    pick     = '0;
    pick_id  = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // 2-bit subtraction wraps naturally, giving the descending rotation.
      idx = start - ID_W'(i);
      if (!pick_vld && req[idx]) begin
        pick_vld  = 1'b1;
        pick_id   = idx;
        pick[idx] = 1'b1;
      end
    end
  end

endmodule : prio_pick4

// File: rtl/req_arbiter.sv
// ---------------------------------------------------------------------------
// req_arbiter -- 4-requester arbiter with bounded grant hold time.
// An owner keeps the grant while its request stays high; if another
// requester is waiting, the grant is revoked after MAX_HOLD cycles. Every
// grant is followed by at least one idle cycle before the next arbitration.
//
// Parameters:
//   MAX_HOLD : max grant cycles while another requester waits (2..255)
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : req_arbiter_if.slave (req in; gnt, gnt_id, gnt_vld out)
// Configuration:
//   ROUND_ROBIN_EN defined   : search starts at (last_owner-1) mod 4
//   ROUND_ROBIN_EN undefined : fixed priority, no pointer register
// ---------------------------------------------------------------------------
module req_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         rst,
  req_arbiter_if.slave bus
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t              state, state_n;
  logic [NUM_REQ-1:0]  gnt_q, gnt_n;
  logic [ID_W-1:0]     gnt_id_q, gnt_id_n;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_n;
  logic [ID_W-1:0]     start;
  logic [NUM_REQ-1:0]  pick;
  logic [ID_W-1:0]     pick_id;
  logic                pick_vld;
  logic                owner_req;
  logic                other_req;

`ifdef ROUND_ROBIN_EN
  logic [ID_W-1:0]     last_owner, last_owner_n;
  assign start = last_owner - ID_W'(1);
`else
  assign start = ID_W'(NUM_REQ - 1);
`endif

  prio_pick4 u_pick (
    .req      (bus.req),
    .start    (start),
    .pick     (pick),
    .pick_id  (pick_id),
    .pick_vld (pick_vld)
  );

  assign owner_req = |(bus.req & gnt_q);
  assign other_req = |(bus.req & ~gnt_q);

  always_comb begin
    state_n    = state;
    gnt_n      = gnt_q;
    gnt_id_n   = gnt_id_q;
    hold_cnt_n = hold_cnt;
`ifdef ROUND_ROBIN_EN
    last_owner_n = last_owner;
`endif
    unique case (state)
      IDLE: begin
        if (pick_vld) begin
          state_n    = GRANT;
          gnt_n      = pick;
          gnt_id_n   = pick_id;
          hold_cnt_n = '0;
`ifdef ROUND_ROBIN_EN
          last_owner_n = pick_id;
`endif
        end
      end
      GRANT: begin
        // Release is tested first, so a release coinciding with a timeout
        // is simply a release; both lead to IDLE anyway.
        if (!owner_req || (hold_cnt == HOLD_LAST && other_req)) begin
          state_n  = IDLE;
          gnt_n    = '0;
          gnt_id_n = '0;
        end else if (hold_cnt != HOLD_LAST) begin
          // Saturates at HOLD_LAST while nobody else is waiting.
          hold_cnt_n = hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        state_n  = IDLE;
        gnt_n    = '0;
        gnt_id_n = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      hold_cnt <= '0;
`ifdef ROUND_ROBIN_EN
      last_owner <= '0;
`endif
    end else begin
      state    <= state_n;
      gnt_q    <= gnt_n;
      gnt_id_q <= gnt_id_n;
      hold_cnt <= hold_cnt_n;
`ifdef ROUND_ROBIN_EN
      last_owner <= last_owner_n;
`endif
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.gnt_vld = |gnt_q;

endmodule : req_arbiter

// File: doc/req_arbiter.md
REQ_ARBITER -- requirements
Module: req_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, 8, maximum cycles one owner keeps the grant while another requester waits (legal range 2..255).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: req  input  4  request vector; req[3]=a (highest fixed priority), req[2]=b, req[1]=c, req[0]=d.
REQ-005 Port: gnt  output  4  one-hot registered grant, bit order as req.
REQ-006 Port: gnt_id  output  2  binary index of granted requester (3=a ... 0=d); 0 when gnt_vld=0.
REQ-007 Port: gnt_vld  output  1  high while any grant is active.

Function
REQ-008 The block shall implement FSM states IDLE and GRANT.
REQ-009 In IDLE with req!=0, the block shall select a winner and, at the next edge, enter GRANT with gnt, gnt_id and gnt_vld registered (req-to-gnt latency 1 cycle).
REQ-010 In IDLE with req==0, the block shall remain in IDLE with gnt=0, gnt_id=0, gnt_vld=0.
REQ-011 In GRANT, the grant shall persist while the owner's req bit stays high, unless preempted per REQ-013.
REQ-012 Owner's req low at an edge: the block shall enter IDLE and clear gnt the following cycle; minimum one idle cycle between grants, including when other requests are pending.
REQ-013 Hold counter: 8 bits, cleared on grant, incremented each GRANT cycle; when count reaches MAX_HOLD-1 and any non-owner req bit is high, the grant shall be revoked (enter IDLE) at that edge.
REQ-014 Counter at MAX_HOLD-1 with no other requester: the counter shall saturate and the grant shall persist.
REQ-015 Simultaneous owner release and timeout shall be treated as a release; result identical (IDLE).
REQ-016 gnt shall never have more than one bit set; gnt_vld shall equal |gnt.
REQ-017 Request bits asserting/deasserting while not owner shall have no effect until the next IDLE evaluation.

Reset
REQ-018 On rst high the block shall immediately enter IDLE, drive gnt=0, gnt_id=0, gnt_vld=0, clear hold counter, and set the round-robin pointer to 0.
REQ-019 Reset asserted mid-grant shall drop the grant without waiting for an edge; first arbitration after release uses reset priority.

Configuration
REQ-020 Macro ROUND_ROBIN_EN defined: search order starts at (last_owner-1) mod 4 and descends with wrap; last_owner updates on each grant; reset pointer 0 gives initial order 3,2,1,0.
REQ-021 Macro ROUND_ROBIN_EN undefined: fixed priority req[3]>req[2]>req[1]>req[0]; no pointer register synthesised.

Structure
REQ-022 Shared package arb_pkg shall hold NUM_REQ=4, ID_W=2, HOLD_W=8, and the IDLE/GRANT state encoding.
REQ-023 Winner selection shall be a combinational sub-module prio_pick4 (inputs req[3:0], start[1:0]; outputs one-hot pick, pick_id, pick_vld); fixed-priority mode ties start to 3.

Verification
REQ-024 Reset, then req=4'b0100 -> one cycle later gnt=4'b0100, gnt_id=2, gnt_vld=1; req=0 -> next cycle gnt=0, gnt_vld=0.
REQ-025 req=4'b0110 -> gnt=4'b0100, id=2; owner drops (req=4'b0010) -> one idle cycle gnt=0, then gnt=4'b0010, id=1.
REQ-026 MAX_HOLD=4, req=4'b1001 held -> gnt=4'b1000 for 4 cycles, one idle cycle; fixed mode re-grants 4'b1000, ROUND_ROBIN_EN grants 4'b0001.
REQ-027 MAX_HOLD=4, req=4'b0001 only, held 20 cycles -> gnt=4'b0001 continuous, no revocation.
REQ-028 Mid-grant gnt=4'b0100, assert rst between edges -> gnt=0, gnt_vld=0 immediately; release with req=4'b1110 -> gnt=4'b1000 one cycle later.
REQ-029 ROUND_ROBIN_EN, req=4'b1111 with each owner releasing after 2 cycles -> grant order 3,2,1,0,3 each separated by one idle cycle.
